// File: rtl/inst_decode_pipe.sv
// MIPS-style instruction decoder feeding a DEPTH-entry FIFO of decoded records; head valid 1 cycle after
// accept into an empty buffer. Backpressure: in_ready drops when full or flushing, never depends on out_ready.
module inst_decode_pipe #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [31:0]              in_inst,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_onehot,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_shamt,
  output logic [31:0]              out_imm,
  output logic [25:0]              out_jidx,
  output logic                     out_illegal,
  output logic [CNT_W-1:0]         illegal_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [31:0] onehot;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [25:0] jidx;
    logic        illegal;
  } rec_t;

  rec_t           mem_q [DEPTH];
  rec_t           mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           run_q, run_d;
  rec_t           dec, head;
  logic [31:0]    sext, zext;
  logic           push, pop;

  always_comb begin
    dec       = '0;
    dec.rs    = in_inst[25:21];
    dec.rt    = in_inst[20:16];
    dec.rd    = in_inst[15:11];
    dec.shamt = in_inst[10:6];
    dec.jidx  = in_inst[25:0];
    sext      = {{16{in_inst[15]}}, in_inst[15:0]};
    zext      = {16'h0, in_inst[15:0]};
    case (in_inst[31:26])
      6'h00: begin
        case (in_inst[5:0])
          6'h20: dec.onehot[0]  = 1'b1;
          6'h21: dec.onehot[1]  = 1'b1;
          6'h23: dec.onehot[2]  = 1'b1;
          6'h22: dec.onehot[3]  = 1'b1;
          6'h24: dec.onehot[4]  = 1'b1;
          6'h25: dec.onehot[5]  = 1'b1;
          6'h26: dec.onehot[6]  = 1'b1;
          6'h27: dec.onehot[7]  = 1'b1;
          6'h2A: dec.onehot[8]  = 1'b1;
          6'h2B: dec.onehot[9]  = 1'b1;
          6'h00: dec.onehot[10] = 1'b1;
          6'h02: dec.onehot[11] = 1'b1;
          6'h03: dec.onehot[12] = 1'b1;
          6'h04: dec.onehot[13] = 1'b1;
          6'h06: dec.onehot[14] = 1'b1;
          6'h07: dec.onehot[15] = 1'b1;
          6'h08: dec.onehot[16] = 1'b1;
          default: ;
        endcase
      end
      6'h08: begin dec.onehot[17] = 1'b1; dec.imm = sext; end
      6'h09: begin dec.onehot[18] = 1'b1; dec.imm = sext; end
      6'h0C: begin dec.onehot[19] = 1'b1; dec.imm = zext; end
      6'h0D: begin dec.onehot[20] = 1'b1; dec.imm = zext; end
      6'h0E: begin dec.onehot[21] = 1'b1; dec.imm = zext; end
      6'h23: begin dec.onehot[22] = 1'b1; dec.imm = sext; end
      6'h2B: begin dec.onehot[23] = 1'b1; dec.imm = sext; end
      6'h04: begin dec.onehot[24] = 1'b1; dec.imm = sext; end
      6'h05: begin dec.onehot[25] = 1'b1; dec.imm = sext; end
      6'h0A: begin dec.onehot[26] = 1'b1; dec.imm = sext; end
      6'h0B: begin dec.onehot[27] = 1'b1; dec.imm = sext; end
      6'h0F: begin dec.onehot[28] = 1'b1; dec.imm = {in_inst[15:0], 16'h0}; end
      6'h02: dec.onehot[29] = 1'b1;
      6'h03: dec.onehot[30] = 1'b1;
      default: ;
    endcase
    dec.illegal = (dec.onehot == '0);
  end

  // run_q holds in_ready low until the first edge after reset release
  assign in_ready  = run_q && (level_q < LW'(DEPTH)) && !flush;
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_onehot  = head.onehot;
  assign out_rs      = head.rs;
  assign out_rt      = head.rt;
  assign out_rd      = head.rd;
  assign out_shamt   = head.shamt;
  assign out_imm     = head.imm;
  assign out_jidx    = head.jidx;
  assign out_illegal = head.illegal;
  assign illegal_cnt = cnt_q;
  assign level       = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    run_d    = 1'b1;
    if (push && dec.illegal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: tb/tb_inst_decode_pipe.sv
// Randomized bench for inst_decode_pipe against a queue-based decode model; a second instance with
// CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_inst_decode_pipe;
  localparam int DEPTH = 4;

  localparam int RF  [17] = '{32'h20, 32'h21, 32'h23, 32'h22, 32'h24, 32'h25, 32'h26, 32'h27, 32'h2A,
                              32'h2B, 32'h00, 32'h02, 32'h03, 32'h04, 32'h06, 32'h07, 32'h08};
  localparam int OPT [14] = '{32'h08, 32'h09, 32'h0C, 32'h0D, 32'h0E, 32'h23, 32'h2B, 32'h04, 32'h05,
                              32'h0A, 32'h0B, 32'h0F, 32'h02, 32'h03};

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic        in_ready, out_valid, out_illegal, in_ready2, out_valid2, out_illegal2;
  logic [31:0] out_onehot, out_imm, out_onehot2, out_imm2;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt, out_rs2, out_rt2, out_rd2, out_shamt2;
  logic [25:0] out_jidx, out_jidx2;
  logic [15:0] illegal_cnt;
  logic [1:0]  illegal_cnt2;
  logic [2:0]  level, level2;

  int          errors = 0, checks = 0;
  logic [31:0] q[$];
  int          m_cnt = 0;
  bit          m_started = 0;

  always #5 clk = ~clk;

  inst_decode_pipe #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid), .out_onehot(out_onehot),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt), .out_imm(out_imm),
    .out_jidx(out_jidx), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt), .level(level));

  inst_decode_pipe #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready2),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid2), .out_onehot(out_onehot2),
    .out_rs(out_rs2), .out_rt(out_rt2), .out_rd(out_rd2), .out_shamt(out_shamt2), .out_imm(out_imm2),
    .out_jidx(out_jidx2), .out_illegal(out_illegal2), .illegal_cnt(illegal_cnt2), .level(level2));

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] m_onehot(logic [31:0] w);
    logic [31:0] oh = '0;
    if (w[31:26] == 6'h00) begin
      for (int i = 0; i < 17; i++) if (int'(w[5:0]) == RF[i]) oh = 32'(1) << i;
    end else begin
      for (int i = 0; i < 14; i++) if (int'(w[31:26]) == OPT[i]) oh = 32'(1) << (17 + i);
    end
    return oh;
  endfunction

  function automatic logic [31:0] m_imm(logic [31:0] w);
    int op = int'(w[31:26]);
    if (op inside {8, 9, 10, 11, 35, 43, 4, 5}) return 32'($signed(w[15:0]));
    if (op inside {12, 13, 14}) return 32'(w[15:0]);
    if (op == 15) return w[15:0] * 32'h10000;
    return 32'h0;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 3))
      0: return {6'h00, r[25:6], 6'(RF[$urandom_range(0, 16)])};
      1: return {6'(OPT[$urandom_range(0, 13)]), r[25:0]};
      2: return {6'h00, r[25:0]};
      default: return r;
    endcase
  endfunction

  task automatic check_outputs();
    bit          v = (q.size() != 0);
    logic [31:0] h = v ? q[0] : 32'h0;
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("level", 64'(level), 64'(q.size()));
    chk("out_onehot", 64'(out_onehot), v ? 64'(m_onehot(h)) : 64'h0);
    chk("out_imm", 64'(out_imm), v ? 64'(m_imm(h)) : 64'h0);
    chk("out_regs", {out_rs, out_rt, out_rd, out_shamt}, v ? 64'(h[25:6]) : 64'h0);
    chk("out_jidx", 64'(out_jidx), 64'(h[25:0]));
    chk("out_illegal", 64'(out_illegal), 64'(v && (m_onehot(h) == 0)));
    chk("illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
    chk("illegal_cnt_sat", 64'(illegal_cnt2), 64'((m_cnt > 3) ? 3 : m_cnt));
  endtask

  // Drive one cycle starting from a falling edge; model advances at the rising edge.
  task automatic step(input bit v, input logic [31:0] inst, input bit ordy, input bit fl);
    bit exp_rdy, push, pop;
    in_valid  = v;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = m_started && (q.size() < DEPTH) && !fl;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    push = v && exp_rdy;
    pop  = (q.size() > 0) && ordy;
    @(posedge clk);
    m_started = 1;
    if (push && (m_onehot(inst) == 0) && (m_cnt < 65535)) m_cnt++;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(inst);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic reset_model();
    q.delete();
    m_cnt     = 0;
    m_started = 0;
  endtask

  initial begin
    #2;
    chk("rst_level", 64'(level), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_cnt", 64'(illegal_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 32'h00851020, 1, 0);

    step(1, 32'h00851020, 1, 0);
    chk("add_valid", 64'(out_valid), 64'h1);
    chk("add_onehot", 64'(out_onehot), 64'h1);
    chk("add_rs_rt_rd", {out_rs, out_rt, out_rd}, {5'd4, 5'd5, 5'd2});
    step(1, 32'h2008FFFF, 1, 0);
    chk("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
    step(1, 32'h3108FFFF, 1, 0);
    chk("andi_imm", 64'(out_imm), 64'h0000FFFF);
    step(1, 32'h3C011234, 1, 0);
    chk("lui_imm", 64'(out_imm), 64'h12340000);
    chk("lui_onehot", 64'(out_onehot), 64'h10000000);
    step(1, 32'hFC000000, 1, 0);
    chk("ill_flag", 64'(out_illegal), 64'h1);
    chk("ill_onehot", 64'(out_onehot), 64'h0);
    chk("ill_cnt1", 64'(illegal_cnt), 64'h1);
    for (int i = 0; i < 4; i++) step(1, 32'hFC000000, 1, 0);
    step(0, 32'h0, 1, 0);
    chk("ill_cnt5", 64'(illegal_cnt), 64'h5);
    chk("ill_cnt_sat3", 64'(illegal_cnt2), 64'h3);

    for (int i = 0; i < DEPTH; i++) step(1, {16'h2008, 16'(i + 1)}, 0, 0);
    chk("full_level", 64'(level), 64'(DEPTH));
    in_valid = 1'b1;
    #1;
    chk("full_in_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    step(1, 32'h2008_0099, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 64'(out_imm), 64'(i + 1));
      step(0, 32'h0, 1, 0);
    end
    chk("drain_level", 64'(level), 64'h0);

    step(1, 32'h00851020, 0, 0);
    step(1, 32'h2008FFFF, 0, 0);
    chk("pre_flush_level", 64'(level), 64'h2);
    step(1, 32'h3108FFFF, 1, 1);
    chk("flush_level", 64'(level), 64'h0);
    chk("flush_valid", 64'(out_valid), 64'h0);
    step(0, 32'h0, 1, 0);
    chk("flush_lost", 64'(level), 64'h0);

    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 9) < 7, rand_inst(), $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);

    for (int i = 0; i < 3; i++) step(1, rand_inst(), 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", 64'(level), 64'h0);
    chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_data", {out_onehot, out_imm}, 64'h0);
    chk("arst_cnt", 64'(illegal_cnt), 64'h0);
    chk("arst_in_ready", 64'(in_ready), 64'h0);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 32'h00851020, 1, 0);
    for (int n = 0; n < 200; n++)
      step($urandom_range(0, 9) < 7, rand_inst(), $urandom_range(0, 9) < 6, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
